// File: rtl/tpm_response_serializer.sv
// Serializes a TPM command result into a big-endian response stream:
// tag(2) | responseSize(4) | responseCode(4) | parameters(N), over a valid/ready byte handshake.
module tpm_response_serializer #(
    parameter int          MAX_PAYLOAD = 64,
    parameter logic [15:0] TAG_NO_SESS = 16'h8001
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rsp_start,
    input  logic [31:0] tpm_rc,
    input  logic [7:0]  payload_len,
    output logic [7:0]  payload_addr,
    input  logic [7:0]  payload_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic        rsp_done,
    output logic        rsp_overrun
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        DONE
    } stateType;

    localparam logic [7:0] maxLen = 8'(MAX_PAYLOAD);
    localparam logic [31:0] rcSize = 32'h0000_0095;

    stateType    state;
    stateType    nextState;
    logic [3:0]  hdrIdx;
    logic [31:0] rcReg;
    logic [7:0]  lenReg;
    logic [31:0] sizeReg;
    logic [7:0]  addrReg;
    logic        overrunReg;

    logic [31:0] startRc;
    logic [7:0]  startLen;
    logic        accept;
    logic        hdrLast;
    logic        payLast;

    assign accept  = tx_valid & tx_ready;
    assign hdrLast = (hdrIdx == 4'd9);
    assign payLast = (addrReg == lenReg - 8'd1);

    // Error responses carry no parameters; an oversize success turns into TPM_RC_SIZE.
    always_comb begin
        startRc  = tpm_rc;
        startLen = payload_len;
        if (tpm_rc != 32'd0) begin
            startLen = 8'd0;
        end else if (payload_len > maxLen) begin
            startRc  = rcSize;
            startLen = 8'd0;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        nextState = state;
        unique case (state)
            IDLE: if (rsp_start) nextState = HDR;
            HDR:  if (accept && hdrLast) nextState = (lenReg == 8'd0) ? DONE : PAY;
            PAY:  if (accept && payLast) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
            state <= nextState;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hdrIdx     <= 4'd0;
            rcReg      <= 32'd0;
            lenReg     <= 8'd0;
            sizeReg    <= 32'd0;
            addrReg    <= 8'd0;
            overrunReg <= 1'b0;
        end else begin
            overrunReg <= rsp_start && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (rsp_start) begin
                        rcReg   <= startRc;
                        lenReg  <= startLen;
                        sizeReg <= 32'd10 + {24'd0, startLen};
                        hdrIdx  <= 4'd0;
                        addrReg <= 8'd0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        hdrIdx <= hdrLast ? 4'd0 : hdrIdx + 4'd1;
                    end
                end
                PAY: begin
                    // Address returns to 0 after the final byte so the next header starts clean.
                    if (accept) begin
                        addrReg <= payLast ? 8'd0 : addrReg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_data = 8'h00;
        unique case (state)
            HDR: begin
                unique case (hdrIdx)
                    4'd0:    tx_data = TAG_NO_SESS[15:8];
                    4'd1:    tx_data = TAG_NO_SESS[7:0];
                    4'd2:    tx_data = sizeReg[31:24];
                    4'd3:    tx_data = sizeReg[23:16];
                    4'd4:    tx_data = sizeReg[15:8];
                    4'd5:    tx_data = sizeReg[7:0];
                    4'd6:    tx_data = rcReg[31:24];
                    4'd7:    tx_data = rcReg[23:16];
                    4'd8:    tx_data = rcReg[15:8];
                    4'd9:    tx_data = rcReg[7:0];
                    default: tx_data = 8'h00;
                endcase
            end
            PAY:     tx_data = payload_data;
            default: tx_data = 8'h00;
        endcase
    end

    assign tx_valid     = (state == HDR) || (state == PAY);
    assign busy         = tx_valid;
    assign rsp_done     = (state == DONE);
    assign rsp_overrun  = overrunReg;
    assign payload_addr = addrReg;
    assign tx_last      = ((state == HDR) && hdrLast && (lenReg == 8'd0)) ||
                          ((state == PAY) && payLast);

endmodule
